// File: rtl/map_draw.sv
// Tile-map read path: turns VGA raster position into a tile RAM read and maps
// the returned tile code to a 12-bit colour, with blinking player heads.
module map_draw #(
  parameter int MAP_W      = 64,
  parameter int MAP_H      = 48,
  parameter int TILE_LOG2  = 4,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  output logic [11:0] map_addr,
  input  logic [1:0]  map_data,
  input  logic [5:0]  p1_head_x,
  input  logic [5:0]  p1_head_y,
  input  logic [5:0]  p2_head_x,
  input  logic [5:0]  p2_head_y,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [BLINK_LOG2:0] CNT_ONE = 1;

  logic [10:0] tx, ty;
  logic        in_map, head_hit;
  logic [11:0] addr_c;

  logic [10:0] s1_vcount, s1_hcount;
  logic        s1_vsync, s1_vblnk, s1_hsync, s1_hblnk, s1_in_map, s1_head;
  logic        s2_in_map, s2_head;

  logic [BLINK_LOG2:0] frame_cnt;
  logic                vblnk_prev;

  always_comb begin
    tx       = hcount_in >> TILE_LOG2;
    ty       = vcount_in >> TILE_LOG2;
    in_map   = (tx < 11'(MAP_W)) && (ty < 11'(MAP_H));
    addr_c   = 12'(ty) * 12'(MAP_W) + 12'(tx);
    head_hit = (tx == 11'(p1_head_x) && ty == 11'(p1_head_y)) ||
               (tx == 11'(p2_head_x) && ty == 11'(p2_head_y));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_addr   <= '0;
      s1_vcount  <= '0;
      s1_vsync   <= 1'b0;
      s1_vblnk   <= 1'b0;
      s1_hcount  <= '0;
      s1_hsync   <= 1'b0;
      s1_hblnk   <= 1'b0;
      s1_in_map  <= 1'b0;
      s1_head    <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      s2_in_map  <= 1'b0;
      s2_head    <= 1'b0;
      vblnk_prev <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      map_addr   <= in_map ? addr_c : 12'd0;
      s1_vcount  <= vcount_in;
      s1_vsync   <= vsync_in;
      s1_vblnk   <= vblnk_in;
      s1_hcount  <= hcount_in;
      s1_hsync   <= hsync_in;
      s1_hblnk   <= hblnk_in;
      s1_in_map  <= in_map;
      s1_head    <= head_hit;
      vcount_out <= s1_vcount;
      vsync_out  <= s1_vsync;
      vblnk_out  <= s1_vblnk;
      hcount_out <= s1_hcount;
      hsync_out  <= s1_hsync;
      hblnk_out  <= s1_hblnk;
      s2_in_map  <= s1_in_map;
      s2_head    <= s1_head;
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) frame_cnt <= frame_cnt + CNT_ONE;
    end
  end

  // map_data arrives together with the stage-2 registers, so colour is decoded
  // combinationally from them to keep the total latency at two clocks.
  always_comb begin
    rgb_out = 12'h000;
    if (!(hblnk_out || vblnk_out) && s2_in_map) begin
      if (s2_head && frame_cnt[BLINK_LOG2] && (map_data == 2'd1 || map_data == 2'd2))
        rgb_out = 12'hfff;
      else begin
        case (map_data)
          2'd0:    rgb_out = 12'h000;
          2'd1:    rgb_out = 12'hf0f;
          2'd2:    rgb_out = 12'h0f0;
          default: rgb_out = 12'h00f;
        endcase
      end
    end
  end

endmodule
